// File: rtl/seg_dec_pkg.sv
// Shared types and constants for the scanned 7-segment read-back decoder.
package seg_dec_pkg;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned WORD_W = DIGITS * NIB_W;
    localparam int unsigned CNT_W  = 8;

    // Segment pattern (gfedcba, active-high) for each hex nibble; entry 15 first.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Nibble reported for a pattern outside the table.
    localparam logic [NIB_W-1:0] SEG_NIB_INVALID = 4'h0;

    function automatic logic is_multi_hot(input logic [DIGITS-1:0] d);
        return (d & (d - DIGITS'(1))) != '0;
    endfunction

    function automatic logic is_one_hot(input logic [DIGITS-1:0] d);
        return (d != '0) && !is_multi_hot(d);
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational lookup of an active-high 7-segment pattern back to its hex nibble.
module seg7_to_hex
    import seg_dec_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [NIB_W-1:0] nib_c,
    output logic             vld_c
);

    always_comb begin
        nib_c = SEG_NIB_INVALID;
        vld_c = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (seg == SEG_TABLE[i]) begin
                nib_c = NIB_W'(i);
                vld_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed 7-segment bus, decodes each dwell and reassembles 16-bit frames.
// Optional SEG_DEC_CHANGE_ONLY_EN: emit a frame only when it differs from the last emitted one.
module seg_scan_decoder
    import seg_dec_pkg::*;
#(
    parameter int unsigned STABLE_CYC  = 4,
    parameter bit          SEG_ACT_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SEG_W-1:0]  ss,
    input  logic [DIGITS:1]   dig,
    output logic [WORD_W-1:0] word,
    output logic              word_vld,
    input  logic              word_rdy,
    output logic              err_seg,
    output logic              err_seq,
    output logic              ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] ACC_AT  = CNT_W'(STABLE_CYC - 1);

    logic [SEG_W-1:0]  ss_q, ss_p;
    logic [DIGITS:1]   dig_q, dig_p;
    logic [CNT_W-1:0]  cnt;
    state_t            state;
    logic [DIGITS:1]   exp_dig;
    logic [WORD_W-1:0] frame;
    logic              bad;

    logic [SEG_W-1:0]  seg_ah_c;
    logic [NIB_W-1:0]  nib_c;
    logic              nib_vld_c;
    logic              acc_c;
    logic              frame_new_c;
    logic              load_c;
    logic              drop_c;

    // Input sampling plus a one-cycle history for stability detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_q  <= '0;
            dig_q <= '0;
            ss_p  <= '0;
            dig_p <= '0;
        end else begin
            ss_q  <= ss;
            dig_q <= dig;
            ss_p  <= ss_q;
            dig_p <= dig_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if ({dig_q, ss_q} != {dig_p, ss_p}) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // dig_p/ss_p hold the value whose dwell the counter is measuring.
    assign acc_c    = (cnt == ACC_AT);
    assign seg_ah_c = SEG_ACT_LOW ? ~ss_p : ss_p;

    seg7_to_hex u_seg7_to_hex (
        .seg   (seg_ah_c),
        .nib_c (nib_c),
        .vld_c (nib_vld_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SYNC;
            exp_dig <= 4'b0010;
            frame   <= '0;
            bad     <= 1'b0;
            err_seg <= 1'b0;
            err_seq <= 1'b0;
        end else begin
            err_seg <= acc_c && is_one_hot(dig_p) && !nib_vld_c;
            err_seq <= 1'b0;
            case (state)
                SYNC: begin
                    if (acc_c && dig_p == 4'b0001) begin
                        frame   <= {12'h000, nib_c};
                        bad     <= !nib_vld_c;
                        exp_dig <= 4'b0010;
                        state   <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (is_multi_hot(dig_q)) begin
                        err_seq <= 1'b1;
                        state   <= SYNC;
                    end else if (acc_c && dig_p != '0) begin
                        if (dig_p == exp_dig) begin
                            frame <= {frame[WORD_W-NIB_W-1:0], nib_c};
                            bad   <= bad || !nib_vld_c;
                            if (exp_dig == 4'b1000) begin
                                state <= EMIT;
                            end else begin
                                exp_dig <= {exp_dig[DIGITS-1:1], 1'b0};
                            end
                        end else begin
                            err_seq <= 1'b1;
                            if (dig_p == 4'b0001) begin
                                frame   <= {12'h000, nib_c};
                                bad     <= !nib_vld_c;
                                exp_dig <= 4'b0010;
                            end else begin
                                state <= SYNC;
                            end
                        end
                    end
                end
                EMIT:    state <= SYNC;
                default: state <= SYNC;
            endcase
        end
    end

`ifdef SEG_DEC_CHANGE_ONLY_EN
    logic [WORD_W-1:0] last_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_word <= '0;
        end else if (load_c) begin
            last_word <= frame;
        end
    end

    assign frame_new_c = (frame != last_word);
`else
    assign frame_new_c = 1'b1;
`endif

    assign load_c = (state == EMIT) && !bad && frame_new_c && (!word_vld || word_rdy);
    assign drop_c = (state == EMIT) && !bad && frame_new_c && word_vld && !word_rdy;

    // Output register: a new load wins over a simultaneous handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word     <= '0;
            word_vld <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (load_c) begin
                word     <= frame;
                word_vld <= 1'b1;
            end else if (word_rdy) begin
                word_vld <= 1'b0;
            end
            if (drop_c) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: vector table plus overflow and reset sequences.
module tb_seg_scan_decoder;

`ifdef SEG_DEC_CHANGE_ONLY_EN
    localparam bit CHG_ONLY = 1'b1;
`else
    localparam bit CHG_ONLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  ss;
    logic [4:1]  dig;
    logic [15:0] word;
    logic        word_vld;
    logic        word_rdy;
    logic        err_seg;
    logic        err_seq;
    logic        ovf;

    seg_scan_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ss       (ss),
        .dig      (dig),
        .word     (word),
        .word_vld (word_vld),
        .word_rdy (word_rdy),
        .err_seg  (err_seg),
        .err_seq  (err_seq),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w;
        int          dwell;
        int          bad_idx;
        logic [6:0]  bad_pat;
        int          skip_idx;
        int          n_vld;
        int          n_seg;
        int          n_seq;
    } vec_t;

    vec_t        vecs [10];
    int          checks = 0;
    int          errors = 0;
    int          n_vld  = 0;
    int          n_seg  = 0;
    int          n_seq  = 0;
    logic [15:0] exp_q [$];
    logic [15:0] exp_w;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scan one frame on active-low lines, then blank the display.
    task automatic scan(input logic [15:0] w, input int dwell, input int bad_idx,
                        input logic [6:0] bad_pat, input int skip_idx);
        for (int i = 1; i <= 4; i++) begin
            if (i != skip_idx) begin
                logic [3:0] nib;
                nib = w[(4-i)*4 +: 4];
                dig = 4'(1 << (i - 1));
                ss  = ~((i == bad_idx) ? bad_pat : seg_of(nib));
                repeat (dwell) tick();
            end
        end
        dig = 4'b0000;
        ss  = 7'h7F;
        repeat (8) tick();
    endtask

    // Scoreboard and pulse counters.
    always @(negedge clk) begin
        if (rst_n) begin
            if (word_vld && word_rdy) begin
                n_vld++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL word_unexpected: got %h expected none", word);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (word !== exp_w) begin
                        errors++;
                        $display("FAIL word: got %h expected %h", word, exp_w);
                    end
                end
            end
            if (err_seg) n_seg++;
            if (err_seq) n_seq++;
        end
    end

    initial begin
        int v0, s0, q0;

        vecs[0] = '{16'h1A3F, 8, 0, 7'h00, 0, 1, 0, 0};
        vecs[1] = '{16'h1A3F, 3, 0, 7'h00, 0, 0, 0, 0};
        vecs[2] = '{16'h1234, 8, 3, 7'h49, 0, 0, 1, 0};
        vecs[3] = '{16'h1234, 8, 0, 7'h00, 3, 0, 0, 1};
        vecs[4] = '{16'h1234, 8, 0, 7'h00, 0, 1, 0, 0};
        vecs[5] = '{16'h5555, 4, 0, 7'h00, 0, 1, 0, 0};
        vecs[6] = '{16'h5555, 4, 0, 7'h00, 0, CHG_ONLY ? 0 : 1, 0, 0};
        vecs[7] = '{16'h0000, 5, 0, 7'h00, 0, 1, 0, 0};
        vecs[8] = '{16'hFEDC, 6, 0, 7'h00, 0, 1, 0, 0};
        vecs[9] = '{16'h89B7, 4, 0, 7'h00, 0, 1, 0, 0};

        rst_n    = 1'b0;
        ss       = 7'h7F;
        dig      = 4'b0000;
        word_rdy = 1'b1;
        repeat (3) tick();
        chk("rst_word", 32'(word), 32'h0);
        chk("rst_word_vld", 32'(word_vld), 32'h0);
        chk("rst_err_seg", 32'(err_seg), 32'h0);
        chk("rst_err_seq", 32'(err_seq), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        rst_n = 1'b1;
        repeat (4) tick();

        for (int i = 0; i < 10; i++) begin
            v0 = n_vld;
            s0 = n_seg;
            q0 = n_seq;
            if (vecs[i].n_vld != 0) exp_q.push_back(vecs[i].w);
            scan(vecs[i].w, vecs[i].dwell, vecs[i].bad_idx, vecs[i].bad_pat, vecs[i].skip_idx);
            chk($sformatf("vec%0d_vld_cnt", i), 32'(n_vld - v0), 32'(vecs[i].n_vld));
            chk($sformatf("vec%0d_seg_cnt", i), 32'(n_seg - s0), 32'(vecs[i].n_seg));
            chk($sformatf("vec%0d_seq_cnt", i), 32'(n_seq - q0), 32'(vecs[i].n_seq));
        end

        // Back-pressure: second frame dropped, first held and then transferred once.
        word_rdy = 1'b0;
        v0 = n_vld;
        scan(16'h1111, 6, 0, 7'h00, 0);
        chk("hold_vld", 32'(word_vld), 32'h1);
        chk("hold_word", 32'(word), 32'h1111);
        chk("hold_ovf_clear", 32'(ovf), 32'h0);
        scan(16'h2222, 6, 0, 7'h00, 0);
        chk("ovf_set", 32'(ovf), 32'h1);
        chk("ovf_word_held", 32'(word), 32'h1111);
        exp_q.push_back(16'h1111);
        word_rdy = 1'b1;
        repeat (3) tick();
        chk("ovf_drain_vld", 32'(word_vld), 32'h0);
        chk("ovf_drain_cnt", 32'(n_vld - v0), 32'h1);
        chk("ovf_sticky", 32'(ovf), 32'h1);

        // Asynchronous reset in the middle of a frame.
        dig = 4'b0001; ss = ~seg_of(4'h9); repeat (6) tick();
        dig = 4'b0010; ss = ~seg_of(4'h9); repeat (6) tick();
        dig = 4'b0100; ss = ~seg_of(4'h9); repeat (2) tick();
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_word", 32'(word), 32'h0);
        chk("midrst_word_vld", 32'(word_vld), 32'h0);
        chk("midrst_ovf", 32'(ovf), 32'h0);
        chk("midrst_err_seg", 32'(err_seg), 32'h0);
        chk("midrst_err_seq", 32'(err_seq), 32'h0);
        dig = 4'b0000;
        ss  = 7'h7F;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        v0 = n_vld;
        exp_q.push_back(16'hABCD);
        scan(16'hABCD, 5, 0, 7'h00, 0);
        chk("post_rst_vld_cnt", 32'(n_vld - v0), 32'h1);

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the multiplexed 7-segment driver: it samples the scanned segment bus (`ss`) and the digit strobes (`dig`), decodes each digit's segment pattern back to a hex nibble and reassembles the displayed 16-bit word. Completed frames are offered on a valid/ready output. The block sits beside the display driver as an in-system checker: the comparison logic reads back what was actually shown and compares it with what the generator and FIFO path sent.

## Interface
- `STABLE_CYC`, default 4: consecutive identical sampled cycles of `dig`+`ss` required before a digit is accepted (range 2..255).
- `SEG_ACT_LOW`, default 1: 1 means segment lines are active-low; 0 means active-high.
- `CLK` input 1: single clock; `ss`/`dig` are synchronous to it.
- `RST` input 1: asynchronous, active-low reset.
- `ss` input 7: segments, bit0 = a … bit6 = g.
- `dig` input 4 (`[4:1]`): digit strobes, active-high, one-hot or all-zero (blanking).
- `word` output 16: decoded frame; `dig[1]` → `word[15:12]` … `dig[4]` → `word[3:0]`.
- `word_vld` output 1: frame available.
- `word_rdy` input 1: consumer accepts the frame when `word_vld && word_rdy`.
- `err_seg` output 1: one-cycle pulse when an accepted digit has a non-hex segment pattern.
- `err_seq` output 1: one-cycle pulse on an out-of-order or multi-hot strobe.
- `ovf` output 1: sticky; a completed frame was dropped. Cleared only by reset.

## Operation
- Inputs are registered once (`ss_q`, `dig_q`). All decisions use the registered values.
- If `SEG_ACT_LOW`=1, `ss_q` is inverted before decoding.
- Stability counter:
  - Reset to 0 whenever `{dig_q, ss_q}` differs from the previous cycle.
  - Otherwise increments, saturating at `STABLE_CYC`.
  - A digit is "accepted" on the cycle the counter reaches `STABLE_CYC-1`. That is exactly once per dwell.
- Decode table, pattern gfedcba → nibble: 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F. Any other pattern is invalid: nibble 0, `err_seg` pulses, the frame is marked bad.
- FSM states:
  - **SYNC**: wait for an accepted `dig_q`=0001, then latch the nibble and go to COLLECT with expected index 2.
  - **COLLECT**:
    - Accepted digit equal to expected: latch nibble, increment index. After index 4 go to EMIT.
    - Accepted one-hot digit not equal to expected: `err_seq` pulses, partial frame discarded. If that digit is `dig[1]`, latch it and restart at index 2; otherwise go to SYNC.
    - Multi-hot `dig_q` (stable or not): `err_seq` pulses, go to SYNC.
    - `dig_q`=0000: ignored; never accepted, no abort.
  - **EMIT** (1 cycle):
    - If the output register is free (`!word_vld`, or `word_rdy` this cycle), load `word` and set `word_vld`.
    - Otherwise drop the frame and set `ovf`.
    - Frames marked bad are never loaded.
    - Always go to SYNC.
- `word_vld` clears on the handshake. A load in the same cycle as the handshake takes priority: `word_vld` stays 1 with the new word.
- `word` holds its value while `word_vld`=1.

## Timing
- Reset values: `word`=0, `word_vld`=0, `err_seg`=0, `err_seq`=0, `ovf`=0, FSM=SYNC, counter=0, input registers=0.
- Reset mid-frame discards all partial data immediately (asynchronous).
- Digit acceptance occurs `STABLE_CYC` cycles after the first pin cycle of a stable dwell (1 input-register cycle plus `STABLE_CYC-1` counting cycles).
- `word_vld` rises 2 cycles after digit 4 is accepted (latch, then EMIT).
- Error pulses come 1 cycle after the offending acceptance or detection.
- A dwell shorter than `STABLE_CYC` cycles is ignored (glitch rejection).

## Configuration
- `SEG_DEC_CHANGE_ONLY_EN`
  - Defined: EMIT loads only if the new frame differs from the last emitted frame. The last-emitted register resets to 0, so a first frame of 0x0000 is suppressed. Identical frames are discarded silently and never raise `ovf`.
  - Undefined: every good completed frame is emitted.

## Structure
- Package `seg_dec_pkg`: FSM state enum (SYNC, COLLECT, EMIT), `DIGITS`=4, the 16-entry segment-pattern constant array, and the invalid-pattern marker.
- Sub-module `seg7_to_hex`: combinational; inputs 7-bit active-high pattern; outputs 4-bit nibble and a valid bit. Instantiated once in `seg_scan_decoder`.

## Test plan
- Reset, then scan 0x1A3F (patterns 06, 77, 4F, 71 on `dig` 1..4, 8 cycles each, active-low lines), `word_rdy`=1 → `word_vld` pulses with `word`=0x1A3F; no error pulses.
- Same scan with 3-cycle dwells (`STABLE_CYC`=4) → no acceptance, `word_vld` stays 0.
- Digit 3 pattern 0x49 → one `err_seg` pulse; frame not emitted.
- Strobe order 1, 2, 4 → `err_seq` pulse on digit 4; FSM returns to SYNC; the next clean scan 0x1234 is emitted.
- Hold `word_rdy`=0 across two complete scans → first word held, `ovf`=1. After `word_rdy`, that word transfers once and `word_vld`=0.
- With `SEG_DEC_CHANGE_ONLY_EN`: two identical scans of 0x5555 → exactly one `word_vld`. Pulling `RST` low mid-frame → all outputs return to 0 immediately.
